// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_arbiter
// Brief    : Two-port round-robin arbiter in front of a shared single-port RAM,
//            with a one-cycle response path routed back to the granted port.
// Revision : 1.0
// ============================================================================
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,

    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   rr_q,    rr_d;
    logic   owner_q, owner_d;

    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_any_gnt;

    // rr_q names the winner only when both ports contend.
    always_comb begin
        w_gnt0    = rstn_i & p0_req_i & (~p1_req_i | (rr_q == 1'b0));
        w_gnt1    = rstn_i & p1_req_i & (~p0_req_i | (rr_q == 1'b1));
        w_any_gnt = w_gnt0 | w_gnt1;
    end

    always_comb begin
        rr_d    = rr_q;
        owner_d = owner_q;
        state_d = ST_IDLE;
        if (w_gnt0) begin
            rr_d    = 1'b1;
            owner_d = 1'b0;
            state_d = ST_RESP;
        end else if (w_gnt1) begin
            rr_d    = 1'b0;
            owner_d = 1'b1;
            state_d = ST_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // RAM command bus is zero whenever nothing is granted.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (w_gnt1) begin
            ram_en_o    = 1'b1;
            ram_we_o    = p1_we_i;
            ram_addr_o  = p1_addr_i;
            ram_be_o    = p1_be_i;
            ram_wdata_o = p1_wdata_i;
        end else if (w_gnt0) begin
            ram_en_o    = 1'b1;
            ram_we_o    = p0_we_i;
            ram_addr_o  = p0_addr_i;
            ram_be_o    = p0_be_i;
            ram_wdata_o = p0_wdata_i;
        end
    end

    // A pending response is dropped as soon as reset is asserted.
    always_comb begin
        p0_gnt_o    = w_gnt0;
        p1_gnt_o    = w_gnt1;
        p0_rvalid_o = rstn_i & (state_q == ST_RESP) & (owner_q == 1'b0);
        p1_rvalid_o = rstn_i & (state_q == ST_RESP) & (owner_q == 1'b1);
        p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
        p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_arbiter
// Brief    : Directed self-checking bench for sp_ram_arbiter.
// Revision : 1.0
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [3:0]    p0_be_i, p1_be_i;
    logic [DW-1:0] p0_wdata_i, p1_wdata_i;
    logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .p0_req_i    (p0_req_i),
        .p0_addr_i   (p0_addr_i),
        .p0_we_i     (p0_we_i),
        .p0_be_i     (p0_be_i),
        .p0_wdata_i  (p0_wdata_i),
        .p0_gnt_o    (p0_gnt_o),
        .p0_rvalid_o (p0_rvalid_o),
        .p0_rdata_o  (p0_rdata_o),
        .p1_req_i    (p1_req_i),
        .p1_addr_i   (p1_addr_i),
        .p1_we_i     (p1_we_i),
        .p1_be_i     (p1_be_i),
        .p1_wdata_i  (p1_wdata_i),
        .p1_gnt_o    (p1_gnt_o),
        .p1_rvalid_o (p1_rvalid_o),
        .p1_rdata_o  (p1_rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_p0(input logic req, input logic [AW-1:0] addr, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] wd);
        p0_req_i = req; p0_addr_i = addr; p0_we_i = we; p0_be_i = be; p0_wdata_i = wd;
    endtask

    task automatic set_p1(input logic req, input logic [AW-1:0] addr, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] wd);
        p1_req_i = req; p1_addr_i = addr; p1_we_i = we; p1_be_i = be; p1_wdata_i = wd;
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic g0, input logic g1);
        chk({tag, "_gnt0"}, 64'(p0_gnt_o), 64'(g0));
        chk({tag, "_gnt1"}, 64'(p1_gnt_o), 64'(g1));
    endtask

    task automatic chk_rv(input string tag, input logic v0, input logic v1);
        chk({tag, "_rvalid0"}, 64'(p0_rvalid_o), 64'(v0));
        chk({tag, "_rvalid1"}, 64'(p1_rvalid_o), 64'(v1));
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, "_ram_en"},    64'(ram_en_o),    64'd0);
        chk({tag, "_ram_we"},    64'(ram_we_o),    64'd0);
        chk({tag, "_ram_addr"},  64'(ram_addr_o),  64'd0);
        chk({tag, "_ram_be"},    64'(ram_be_o),    64'd0);
        chk({tag, "_ram_wdata"}, 64'(ram_wdata_o), 64'd0);
    endtask

    initial begin
        rstn_i      = 1'b0;
        ram_rdata_i = 32'h0;
        set_p0(1'b1, 15'h0123, 1'b1, 4'hF, 32'h12345678);
        set_p1(1'b1, 15'h0456, 1'b1, 4'hF, 32'h9ABCDEF0);

        // Reset held with both ports requesting: no grant, no RAM command
        step(); step(); settle();
        chk_gnt("rst_both_req", 1'b0, 1'b0);
        chk("rst_ram_en", 64'(ram_en_o), 64'd0);
        chk("rst_ram_we", 64'(ram_we_o), 64'd0);

        // Out of reset, idle
        step();
        rstn_i = 1'b1;
        set_p0(1'b0, '0, 1'b0, 4'h0, '0);
        set_p1(1'b0, '0, 1'b0, 4'h0, '0);
        ram_rdata_i = 32'hFFFF_FFFF;
        settle();
        chk_rv("post_rst", 1'b0, 1'b0);
        chk("post_rst_rdata0", 64'(p0_rdata_o), 64'd0);
        chk("post_rst_rdata1", 64'(p1_rdata_o), 64'd0);
        chk_ram_idle("post_rst");

        // p0 read at 0x010
        step();
        set_p0(1'b1, 15'h0010, 1'b0, 4'hF, 32'h0);
        settle();
        chk_gnt("p0_rd", 1'b1, 1'b0);
        chk("p0_rd_ram_en",   64'(ram_en_o),   64'd1);
        chk("p0_rd_ram_we",   64'(ram_we_o),   64'd0);
        chk("p0_rd_ram_addr", 64'(ram_addr_o), 64'h010);

        step();
        set_p0(1'b0, '0, 1'b0, 4'h0, '0);
        ram_rdata_i = 32'hA5A5_1234;
        settle();
        chk_rv("p0_rd_resp", 1'b1, 1'b0);
        chk("p0_rd_rdata0", 64'(p0_rdata_o), 64'hA5A5_1234);
        chk("p0_rd_rdata1", 64'(p1_rdata_o), 64'd0);
        chk("p0_rd_resp_ram_en", 64'(ram_en_o), 64'd0);

        // p1 write to top of range
        step();
        set_p1(1'b1, 15'h7FFC, 1'b1, 4'hF, 32'hDEADBEEF);
        settle();
        chk_gnt("p1_wr", 1'b0, 1'b1);
        chk("p1_wr_ram_en",    64'(ram_en_o),    64'd1);
        chk("p1_wr_ram_we",    64'(ram_we_o),    64'd1);
        chk("p1_wr_ram_addr",  64'(ram_addr_o),  64'h7FFC);
        chk("p1_wr_ram_be",    64'(ram_be_o),    64'hF);
        chk("p1_wr_ram_wdata", 64'(ram_wdata_o), 64'hDEADBEEF);

        step();
        set_p1(1'b0, '0, 1'b0, 4'h0, '0);
        ram_rdata_i = 32'h1111_2222;
        settle();
        chk_rv("p1_wr_resp", 1'b0, 1'b1);
        chk("p1_wr_rdata1", 64'(p1_rdata_o), 64'h1111_2222);

        // Three idle cycles: RAM quiet, no responses
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            chk_ram_idle($sformatf("idle%0d", i));
            chk_rv($sformatf("idle%0d", i), 1'b0, 1'b0);
        end

        // rr_q still 0 after idle (last grant was p1): contention goes to p0
        step();
        set_p0(1'b1, 15'h0100, 1'b0, 4'hF, '0);
        set_p1(1'b1, 15'h0200, 1'b0, 4'hF, '0);
        settle();
        chk_gnt("idle_then_both", 1'b1, 1'b0);
        chk("idle_then_both_addr", 64'(ram_addr_o), 64'h100);

        // Reset in the cycle after a p0 grant
        step();
        rstn_i = 1'b0;
        settle();
        chk_gnt("rst_after_gnt", 1'b0, 1'b0);
        chk("rst_after_gnt_ram_en", 64'(ram_en_o), 64'd0);

        // Both requesting continuously from reset: p0,p1,p0,p1
        step();
        rstn_i = 1'b1;
        ram_rdata_i = 32'hC0DE_0001;
        settle();
        chk("rst_discard_rvalid0", 64'(p0_rvalid_o), 64'd0);
        chk_gnt("rr_c0", 1'b1, 1'b0);
        chk("rr_c0_addr", 64'(ram_addr_o), 64'h100);

        step(); settle();
        chk_gnt("rr_c1", 1'b0, 1'b1);
        chk("rr_c1_addr", 64'(ram_addr_o), 64'h200);
        chk_rv("rr_c1", 1'b1, 1'b0);
        chk("rr_c1_rdata0", 64'(p0_rdata_o), 64'hC0DE_0001);

        step(); settle();
        chk_gnt("rr_c2", 1'b1, 1'b0);
        chk_rv("rr_c2", 1'b0, 1'b1);

        step(); settle();
        chk_gnt("rr_c3", 1'b0, 1'b1);
        chk_rv("rr_c3", 1'b1, 1'b0);

        step();
        set_p0(1'b0, '0, 1'b0, 4'h0, '0);
        set_p1(1'b0, '0, 1'b0, 4'h0, '0);
        settle();
        chk_gnt("rr_c4", 1'b0, 1'b0);
        chk_rv("rr_c4", 1'b0, 1'b1);

        // Alternating singles then contention: p1 granted last, so p0 wins
        step();
        set_p0(1'b1, 15'h0044, 1'b0, 4'h3, '0);
        settle();
        chk_gnt("alt_p0", 1'b1, 1'b0);

        step();
        set_p0(1'b0, '0, 1'b0, 4'h0, '0);
        set_p1(1'b1, 15'h0088, 1'b0, 4'hC, '0);
        settle();
        chk_gnt("alt_p1", 1'b0, 1'b1);
        chk_rv("alt_p1", 1'b1, 1'b0);

        step();
        set_p0(1'b1, 15'h00CC, 1'b0, 4'h1, '0);
        settle();
        chk_gnt("alt_both", 1'b1, 1'b0);
        chk_rv("alt_both", 1'b0, 1'b1);
        chk("alt_both_addr", 64'(ram_addr_o), 64'h0CC);
        chk("alt_both_be",   64'(ram_be_o),   64'h1);

        step();
        set_p0(1'b0, '0, 1'b0, 4'h0, '0);
        set_p1(1'b0, '0, 1'b0, 4'h0, '0);
        settle();
        chk_rv("alt_end", 1'b1, 1'b0);

        step(); settle();
        chk_rv("final_idle", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
